eth_mac_send: RTL
=================

# eth_mac_send

Ethernet II MAC transmit framer placed directly downstream of the IP/UDP packet generator. On a packet request it emits, on a GMII-style byte interface: the preamble and SFD, the 14-byte Ethernet header, the IP byte stream pulled from the upstream stage, zero padding up to the minimum frame size, and the CRC-32 FCS, followed by the inter-frame gap. It triggers the upstream generator with a one-cycle pulse. The upstream stage's first byte arrives a fixed, known number of cycles after that pulse.

## Interface
- `ETH_TYPE`, 16'h0800: EtherType field.
- `IP_LAT`, 2: cycles from the `ip_trig` cycle to the cycle in which IP byte 0 is valid on `ip_data`. Legal range 1..14.
- `IFG_CYCLES`, 12: idle cycles after the FCS before the next frame may start.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `pkt_trig` input 1: frame request; sampled only in IDLE.
- `dst_mac` input 48: destination MAC; latched on accept.
- `src_mac` input 48: source MAC; latched on accept.
- `ip_len` input 16: IP total length in bytes; latched on accept.
- `ip_data` input 8: IP byte stream from the upstream generator.
- `ip_trig` output 1: one-cycle start pulse to the upstream generator.
- `gmii_tx_en` output 1: frame valid, registered.
- `gmii_txd` output 8: frame byte, registered.
- `busy` output 1: high from accept through the end of the IFG.
- `tx_done` output 1: one-cycle pulse in the last IFG cycle.
- `len_err` output 1: one-cycle pulse when `pkt_trig` is rejected.

## Operation
- States: IDLE → PREAMBLE (8) → ETH_HDR (14) → IP_DATA (latched ip_len) → PAD (max(0, 46 − ip_len)) → FCS (4) → IFG (IFG_CYCLES) → IDLE.
- A single 16-bit byte counter is used per state. It resets to 0 on every state change.
- **Accept:** `pkt_trig` high in IDLE with 20 ≤ ip_len ≤ 1500.
  - `dst_mac`, `src_mac` and `ip_len` are latched.
  - The next state is PREAMBLE.
- **Reject:** `ip_len` < 20 or > 1500.
  - The block stays in IDLE and pulses `len_err`.
  - `ip_trig` is not issued.
- `pkt_trig` is ignored while `busy` is high. No queuing.
- PREAMBLE byte order: 0x55 ×7, then 0xD5.
- ETH_HDR byte order: `dst_mac[47:40]` first through `dst_mac[7:0]`, then `src_mac` in the same order, then `ETH_TYPE[15:8]`, then `ETH_TYPE[7:0]`.
- `ip_trig` is high for exactly one cycle: the ETH_HDR cycle with counter == 14 − IP_LAT.
- IP_DATA cycle k registers `ip_data` onto `gmii_txd`. This is the byte valid IP_LAT + k cycles after the `ip_trig` cycle.
- PAD bytes are 0x00.
- **CRC:**
  - IEEE 802.3 CRC-32, reflected form (poly 0xEDB88320), init 0xFFFFFFFF.
  - Updated over every ETH_HDR, IP_DATA and PAD byte. It does not cover the preamble or SFD.
  - FCS bytes sent: `~crc[7:0]`, `~crc[15:8]`, `~crc[23:16]`, `~crc[31:24]`.
- During IFG and IDLE: `gmii_tx_en` = 0 and `gmii_txd` = 0x00.

## Timing
- **Reset values:** `gmii_tx_en` 0, `gmii_txd` 0x00, `ip_trig` 0, `busy` 0, `tx_done` 0, `len_err` 0. State is IDLE and the CRC register is 0xFFFFFFFF.
- **Accept (edge E):**
  - `busy` is high and `gmii_tx_en`/`gmii_txd` = 1/0x55 from edge E+1.
  - `len_err`, when rejecting, is high for the cycle after edge E.
- `gmii_tx_en` is continuously high for 8 + 14 + max(ip_len, 46) + 4 cycles.
- `tx_done` is high for one cycle, at the last IFG cycle. `busy` falls on the following edge.
- Back-to-back frames: the next accept is possible in the cycle after `busy` falls. The minimum frame-to-frame spacing is therefore frame cycles + IFG_CYCLES + 1.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The frame is truncated and no FCS is sent.
- `ip_len` = 46: PAD is skipped; FCS follows IP_DATA directly.
- `ip_len` = 1500: byte counter maximum 1499; no overflow.

## Configuration
- Macro: `ETH_MAC_PAD_EN`.
  - **Defined:** PAD state present; every frame carries ≥ 46 payload bytes, so it is ≥ 64 bytes including the FCS.
  - **Undefined:** PAD state removed; FCS immediately follows the last IP byte, and `gmii_tx_en` length is 8 + 14 + ip_len + 4.

## Test plan
- **Minimum packet:** ip_len=20, dst_mac=FF:FF:FF:FF:FF:FF, src_mac=00:0A:35:01:02:03; upstream model with IP_LAT=2.
  - `ip_trig` occurs at ETH_HDR count 12.
  - `gmii_tx_en` is high for 72 cycles; bytes 42..67 are 0x00.
  - CRC-32 over header+payload+FCS gives residue 0xC704DD7B.
- **Long packet:** ip_len=1000 with incrementing payload bytes.
  - 1026 `tx_en` cycles, no PAD, payload byte k = k mod 256 at the correct cycle, valid FCS.
- **Length rejection:** `pkt_trig` with ip_len=19, then with ip_len=1501.
  - Each yields a one-cycle `len_err`, no `ip_trig`, `busy` stays 0.
- **Back-to-back requests:** `pkt_trig` held high continuously with ip_len=46.
  - Frames of 72 `tx_en` cycles separated by exactly 13 idle cycles.
  - `tx_done` occurs once per frame; triggers raised while `busy` is high are ignored.
- **Reset mid-frame:** `rst_n` pulsed low during IP_DATA byte 10.
  - Outputs are 0 immediately; after release a new request produces a complete, CRC-valid frame.
- **Padding compiled out:** build without `ETH_MAC_PAD_EN`, ip_len=20.
  - 46 `tx_en` cycles, FCS valid over the 34-byte frame.

Source files
------------

// File: rtl/eth_mac_send.sv
// Ethernet II MAC transmit framer: preamble/SFD, header, IP payload,
// optional zero pad, CRC-32 FCS and inter-frame gap on a GMII byte bus.
// Ports: clk, rst_n (async low); pkt_trig/dst_mac/src_mac/ip_len request;
//   ip_data in, ip_trig out to the upstream generator;
//   gmii_tx_en/gmii_txd frame bus; busy, tx_done, len_err status.
// Build option: define ETH_MAC_PAD_EN to pad payloads to 46 bytes.
module eth_mac_send #(
   parameter logic [15:0] ETH_TYPE   = 16'h0800,
   parameter int          IP_LAT     = 2,
   parameter int          IFG_CYCLES = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pkt_trig,
   input  logic [47:0] dst_mac,
   input  logic [47:0] src_mac,
   input  logic [15:0] ip_len,
   input  logic [7:0]  ip_data,
   output logic        ip_trig,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic        busy,
   output logic        tx_done,
   output logic        len_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_IP,
      S_PAD,
      S_FCS,
      S_IFG
   } state_t;

   localparam logic [15:0] TRIG_CNT = 16'(14 - IP_LAT);
   localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

   state_t        state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [47:0]   dst_q, src_q;
   logic [15:0]   len_q;
   logic [31:0]   crc, crc_n;
   logic [111:0]  hdr;
   logic [3:0]    hidx;
   logic [1:0]    fidx;
   logic          accept, reject;
   logic          en_c, crc_upd, done_c;
   logic [7:0]    byte_c;

   // One byte of the reflected CRC-32, LSB first.
   function automatic logic [31:0] crc_byte(
      input logic [31:0] c_in,
      input logic [7:0]  d
   );
      logic [31:0] c;
      c = c_in ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
         else      c = c >> 1;
      end
      return c;
   endfunction

   assign hdr  = {dst_q, src_q, ETH_TYPE};
   assign hidx = 4'd13 - cnt[3:0];
   assign fidx = cnt[1:0];

   // Upstream byte 0 then lands exactly on the first IP_DATA cycle.
   assign ip_trig = (state == S_HDR) && (cnt == TRIG_CNT);

   assign crc_n = crc_byte(crc, byte_c);

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 16'd1;
      accept  = 1'b0;
      reject  = 1'b0;
      en_c    = 1'b0;
      crc_upd = 1'b0;
      done_c  = 1'b0;
      byte_c  = 8'h00;
      unique case (state)
         S_IDLE: begin
            if (pkt_trig) begin
               if (ip_len >= 16'd20 && ip_len <= 16'd1500) begin
                  accept  = 1'b1;
                  state_n = S_PRE;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         S_PRE: begin
            en_c   = 1'b1;
            byte_c = (cnt == 16'd7) ? 8'hD5 : 8'h55;
            if (cnt == 16'd7) state_n = S_HDR;
         end
         S_HDR: begin
            en_c    = 1'b1;
            crc_upd = 1'b1;
            byte_c  = hdr[{hidx, 3'b000} +: 8];
            if (cnt == 16'd13) state_n = S_IP;
         end
         S_IP: begin
            en_c    = 1'b1;
            crc_upd = 1'b1;
            byte_c  = ip_data;
            if (cnt == len_q - 16'd1) begin
`ifdef ETH_MAC_PAD_EN
               state_n = (len_q < 16'd46) ? S_PAD : S_FCS;
`else
               state_n = S_FCS;
`endif
            end
         end
`ifdef ETH_MAC_PAD_EN
         S_PAD: begin
            en_c    = 1'b1;
            crc_upd = 1'b1;
            byte_c  = 8'h00;
            if (cnt == 16'd45 - len_q) state_n = S_FCS;
         end
`endif
         S_FCS: begin
            en_c   = 1'b1;
            byte_c = ~crc[{fidx, 3'b000} +: 8];
            if (cnt == 16'd3) state_n = S_IFG;
         end
         S_IFG: begin
            if (cnt == IFG_LAST) begin
               done_c  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (state_n != state || state == S_IDLE) cnt_n = 16'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= 16'd0;
         dst_q      <= 48'd0;
         src_q      <= 48'd0;
         len_q      <= 16'd0;
         crc        <= 32'hFFFFFFFF;
         gmii_tx_en <= 1'b0;
         gmii_txd   <= 8'h00;
         busy       <= 1'b0;
         tx_done    <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         if (accept) begin
            dst_q <= dst_mac;
            src_q <= src_mac;
            len_q <= ip_len;
         end
         if (state == S_IDLE) crc <= 32'hFFFFFFFF;
         else if (crc_upd)    crc <= crc_n;
         gmii_tx_en <= en_c;
         gmii_txd   <= byte_c;
         busy       <= (state != S_IDLE);
         tx_done    <= done_c;
         len_err    <= reject;
      end
   end

endmodule
